// File: rtl/gpr_wport_arb.sv
// GPR write-port arbiter: pipeline writeback (WB) versus multi-cycle unit (MCU).
// MCU results wait in a 2-entry FIFO and drain whenever WB leaves the port free.
// A starvation counter asks the pipeline to freeze WB so the FIFO head can drain.
// A hazard compare against buffered destinations lets ID stall on RAW/WAW.
module gpr_wport_arb #(
    parameter int DW         = 64,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_freeze,
    input  logic          flushpipe,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_stall_req,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_addr,
    input  logic [DW-1:0] mc_data,
    output logic          mc_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data,
    input  logic [AW-1:0] hz_addra,
    input  logic [AW-1:0] hz_addrb,
    input  logic [AW-1:0] hz_addrw,
    output logic          hz_stall,
    output logic [1:0]    mc_pend
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // FIFO storage and control
    logic [AW-1:0] addr_r [2];
    logic [DW-1:0] data_r [2];
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    cnt_r;
    logic [3:0]    starve_r;

    logic          head_valid_s;
    logic          push_s;
    logic          wb_elig_s;
    logic          mc_grant_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_data_s;
    logic [1:0]    ent_valid_s;

    assign head_valid_s = (cnt_r != 2'd0);
    assign mc_ready     = (cnt_r != 2'd2);
    assign push_s       = mc_valid & mc_ready;
    assign wb_elig_s    = wb_we & ~wb_freeze & ~flushpipe;
    // WB is non-deferrable, so the MCU head only gets the port when WB is idle
    assign mc_grant_s   = ~wb_elig_s & head_valid_s;
    assign head_addr_s  = addr_r[rd_ptr_r];
    assign head_data_s  = data_r[rd_ptr_r];
    assign mc_pend      = cnt_r;
    // counter is registered and only compared here, so the request cannot glitch
    assign wb_stall_req = head_valid_s & (starve_r == STARVE_LIM);

    // FIFO pointers, occupancy and entry capture; reset drops buffered entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
            addr_r[0] <= '0;
            addr_r[1] <= '0;
            data_r[0] <= '0;
            data_r[1] <= '0;
        end else begin
            if (push_s) begin
                addr_r[wr_ptr_r] <= mc_addr;
                data_r[wr_ptr_r] <= mc_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (mc_grant_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, mc_grant_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Starvation counter: counts denied cycles of a valid head, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= 4'd0;
        end else if (!head_valid_s || mc_grant_s) begin
            starve_r <= 4'd0;
        end else if (starve_r < STARVE_LIM) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Write-port mux: granted source drives the port, r0 writes are dropped
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (wb_elig_s) begin
            rf_we   = (wb_addr != '0);
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (mc_grant_s) begin
            rf_we   = (head_addr_s != '0);
            rf_addr = head_addr_s;
            rf_data = head_data_s;
        end else begin
            rf_we   = 1'b0;
            rf_addr = '0;
            rf_data = '0;
        end
    end

    // Hazard compare of ID addresses against every valid, non-r0 buffered entry
    always_comb begin
        hz_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            // the head slot is valid with one entry, the other slot only when full
            ent_valid_s[i] = (1'(i) == rd_ptr_r) ? (cnt_r != 2'd0) : (cnt_r == 2'd2);
            if (ent_valid_s[i] && (addr_r[i] != '0) &&
                ((addr_r[i] == hz_addra) || (addr_r[i] == hz_addrb) || (addr_r[i] == hz_addrw))) begin
                hz_stall = 1'b1;
            end else begin
                hz_stall = hz_stall;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Bench for gpr_wport_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_gpr_wport_arb;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_freeze, flushpipe, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_stall_req;
    logic          mc_valid;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] hz_addra, hz_addrb, hz_addrw;
    logic          hz_stall;
    logic [1:0]    mc_pend;

    int n_cmp = 0;
    int n_bad = 0;

    gpr_wport_arb #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .wb_freeze(wb_freeze), .flushpipe(flushpipe),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_stall_req(wb_stall_req),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
        .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .hz_addra(hz_addra), .hz_addrb(hz_addrb), .hz_addrw(hz_addrw),
        .hz_stall(hz_stall), .mc_pend(mc_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   denied;

    initial begin : model_cmp
        logic          elig, grant_mc, e_we, e_hz, e_stall;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        ent_t          ne;
        denied = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                denied = 0;
            end
            elig     = wb_we & ~wb_freeze & ~flushpipe;
            grant_mc = !elig && (q.size() > 0);
            e_we = 1'b0; e_addr = '0; e_data = '0;
            if (elig) begin
                e_we = (wb_addr != 0); e_addr = wb_addr; e_data = wb_data;
            end else if (grant_mc) begin
                e_we = (q[0].a != 0); e_addr = q[0].a; e_data = q[0].d;
            end
            e_hz = 1'b0;
            foreach (q[i]) begin
                if (q[i].a != 0 && (q[i].a == hz_addra || q[i].a == hz_addrb || q[i].a == hz_addrw))
                    e_hz = 1'b1;
            end
            e_stall = (q.size() > 0) && (denied == SMAX);
            chk("m_pend", 64'(mc_pend), 64'(q.size()));
            chk("m_ready", 64'(mc_ready), 64'(q.size() < 2));
            chk("m_rf_we", 64'(rf_we), 64'(e_we));
            chk("m_rf_addr", 64'(rf_addr), 64'(e_addr));
            chk("m_rf_data", rf_data, e_data);
            chk("m_hz", 64'(hz_stall), 64'(e_hz));
            chk("m_stallreq", 64'(wb_stall_req), 64'(e_stall));
            if (!rst) begin
                if (q.size() == 0 || grant_mc) denied = 0;
                else if (denied < SMAX) denied = denied + 1;
                ne.a = mc_addr; ne.d = mc_data;
                if (mc_valid && q.size() < 2) begin
                    if (grant_mc) void'(q.pop_front());
                    q.push_back(ne);
                end else if (grant_mc) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wb_freeze = 1'b0; flushpipe = 1'b0; wb_we = 1'b0;
        wb_addr = 5'd0; wb_data = 64'd0; mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 64'd0;
        hz_addra = 5'd0; hz_addrb = 5'd0; hz_addrw = 5'd0;
        repeat (3) tick;
        rst = 1'b0;
        look;
        chk("rst_ready", 64'(mc_ready), 64'd1);
        chk("rst_pend", 64'(mc_pend), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_stall", 64'(wb_stall_req), 64'd0);
        chk("rst_hz", 64'(hz_stall), 64'd0);

        // MCU only, WB idle
        tick; mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 64'h1234; look;
        chk("mcu_ready", 64'(mc_ready), 64'd1);
        tick; mc_valid = 1'b0; look;
        chk("mcu_we", 64'(rf_we), 64'd1);
        chk("mcu_addr", 64'(rf_addr), 64'd7);
        chk("mcu_data", rf_data, 64'h1234);
        tick; look;
        chk("mcu_pend0", 64'(mc_pend), 64'd0);

        // Contention: WB to r3 every cycle, MCU pushes r5 then r6
        tick; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 64'h33;
              mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 64'h55; look;
        tick; mc_addr = 5'd6; mc_data = 64'h66; look;
        chk("cont_wb_addr", 64'(rf_addr), 64'd3);
        tick; mc_valid = 1'b0; look;
        chk("cont_pend2", 64'(mc_pend), 64'd2);
        chk("cont_ready0", 64'(mc_ready), 64'd0);
        tick; look;
        tick; look;
        chk("cont_nostall", 64'(wb_stall_req), 64'd0);
        tick; look;
        chk("cont_stall", 64'(wb_stall_req), 64'd1);
        chk("cont_wb_still", 64'(rf_addr), 64'd3);
        tick; wb_freeze = 1'b1; look;
        chk("drain_r5_we", 64'(rf_we), 64'd1);
        chk("drain_r5_addr", 64'(rf_addr), 64'd5);
        chk("drain_r5_data", rf_data, 64'h55);
        tick; look;
        chk("drain_r6_addr", 64'(rf_addr), 64'd6);
        chk("drain_r6_data", rf_data, 64'h66);
        chk("drain_stall0", 64'(wb_stall_req), 64'd0);
        tick; wb_freeze = 1'b0; wb_we = 1'b0; look;
        chk("drain_pend0", 64'(mc_pend), 64'd0);
        chk("drain_we0", 64'(rf_we), 64'd0);

        // flushpipe suppresses WB, buffered r4 still drains
        tick; mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 64'h44; look;
        tick; mc_valid = 1'b0; flushpipe = 1'b1; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 64'h99; look;
        chk("flush_we", 64'(rf_we), 64'd1);
        chk("flush_addr", 64'(rf_addr), 64'd4);
        chk("flush_data", rf_data, 64'h44);
        tick; flushpipe = 1'b0; wb_we = 1'b0; look;

        // r0 handling
        tick; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 64'h77; look;
        chk("r0_wb_we", 64'(rf_we), 64'd0);
        tick; wb_we = 1'b0; mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 64'hAA; hz_addra = 5'd0; look;
        tick; mc_valid = 1'b0; look;
        chk("r0_pend1", 64'(mc_pend), 64'd1);
        chk("r0_mc_we", 64'(rf_we), 64'd0);
        chk("r0_hz", 64'(hz_stall), 64'd0);
        tick; look;
        chk("r0_pend0", 64'(mc_pend), 64'd0);

        // Hazard on r12 while WB keeps the port busy
        tick; wb_we = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
              mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 64'hCC; look;
        tick; mc_valid = 1'b0; hz_addrb = 5'd12; look;
        chk("hz_set", 64'(hz_stall), 64'd1);
        tick; wb_we = 1'b0; look;
        chk("hz_drain_cycle", 64'(hz_stall), 64'd1);
        chk("hz_drain_addr", 64'(rf_addr), 64'd12);
        tick; look;
        chk("hz_clear", 64'(hz_stall), 64'd0);

        // Reset with two buffered entries
        tick; wb_we = 1'b1; mc_valid = 1'b1; mc_addr = 5'd13; mc_data = 64'hD; hz_addrw = 5'd14; look;
        tick; mc_addr = 5'd14; mc_data = 64'hE; look;
        tick; mc_valid = 1'b0; look;
        chk("rst2_pend2", 64'(mc_pend), 64'd2);
        chk("rst2_hz", 64'(hz_stall), 64'd1);
        tick; rst = 1'b1; wb_we = 1'b0; look;
        chk("rst2_pend0", 64'(mc_pend), 64'd0);
        chk("rst2_we0", 64'(rf_we), 64'd0);
        chk("rst2_hz0", 64'(hz_stall), 64'd0);
        tick; rst = 1'b0; look;
        chk("rst2_after_we", 64'(rf_we), 64'd0);
        chk("rst2_after_pend", 64'(mc_pend), 64'd0);
        tick; look;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpr_wport_arb.md
Name: gpr_wport_arb

Overview:
- Arbitrates the single GPR write port between pipeline writeback (WB) and a multi-cycle unit (MCU: divider, long-latency load return).
- MCU results enter a 2-entry FIFO. Each one drains into the register file on a cycle when WB is not writing.
- A starvation counter raises a stall request to the pipeline so MCU results cannot wait forever.
- A hazard compare against buffered destinations lets ID stall on RAW/WAW to a pending MCU result.

Parameters:
- DW, 64, GPR data width.
- AW, 5, GPR address width.
- STARVE_MAX, 4, cycles a valid FIFO head may be denied before wb_stall_req asserts (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_freeze  in  1  WB stage frozen; WB write not allowed.
- flushpipe  in  1  exception flush; WB write suppressed.
- wb_we  in  1  WB write request.
- wb_addr  in  AW  WB destination.
- wb_data  in  DW  WB data.
- wb_stall_req  out  1  request to freeze WB so the MCU head can drain.
- mc_valid  in  1  MCU result valid.
- mc_addr  in  AW  MCU destination.
- mc_data  in  DW  MCU data.
- mc_ready  out  1  FIFO can accept this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file write address.
- rf_data  out  DW  register-file write data.
- hz_addra  in  AW  ID read address A for hazard check.
- hz_addrb  in  AW  ID read address B for hazard check.
- hz_addrw  in  AW  ID destination for hazard check.
- hz_stall  out  1  any hz_* address matches a buffered, non-r0 entry.
- mc_pend  out  2  number of buffered entries (0..2).

Behaviour:
- Reset: FIFO empty (mc_pend=0); starvation counter 0; mc_ready=1; wb_stall_req=0; rf_we=0; rf_addr=0; rf_data=0; hz_stall=0.
- Reset mid-operation discards buffered entries with no write.
- Push:
  - mc_ready = (mc_pend != 2), combinational from registered count.
  - Entry captured on the edge where mc_valid & mc_ready.
  - mc_valid while not ready is held by the MCU and is not lost.
- Minimum MCU-to-RF latency: 1 cycle. There is no same-cycle bypass into the write port.
- wb_elig = wb_we & ~wb_freeze & ~flushpipe.
- Grant, combinational each cycle:
  - WB always wins when wb_elig; the pipeline write is non-deferrable.
  - Otherwise, if the FIFO head is valid, mc_grant=1 and the head pops on the edge.
- Write outputs:
  - rf_we = (wb_elig & wb_addr!=0) | (mc_grant & head_addr!=0).
  - rf_addr and rf_data come from the granted source, or are 0 when there is no grant.
- r0 handling: a head with addr 0 still pops but produces no write.
- Simultaneous push and pop at mc_pend=1: count stays 1 and order is preserved (oldest first).
- Push at mc_pend=0 while granting is impossible, since the head is not yet valid.
- FIFO pointers are 1-bit and wrap 1->0.
- Starvation counter:
  - 4-bit, registered.
  - Increments when the head is valid and not granted; saturates at STARVE_MAX.
  - Clears to 0 on mc_grant or when the FIFO is empty.
  - wb_stall_req = head_valid & (cnt == STARVE_MAX), registered-derived and glitch-free.
  - The pipeline answers with wb_freeze; the next cycle without wb_elig grants the head.
- flushpipe affects only the WB path. Buffered MCU entries belong to committed instructions and always drain.
- wb_freeze does not block MCU draining; it makes the port free for it.
- Hazard:
  - hz_stall compares all three hz_* addresses against every valid entry, excluding addr 0.
  - It is purely combinational and clears the cycle after the matching entry pops.
  - ID must stall on hz_stall, which guarantees no WB/MCU write-after-write reordering.
- mc_pend is the registered occupancy count.

Test Plan:
- Reset, idle: after rst deasserts, mc_ready=1, mc_pend=0, rf_we=0, wb_stall_req=0, hz_stall=0.
- MCU only, WB idle: push addr 7 / data 0x1234 at cycle N. At N+1, rf_we=1, rf_addr=7, rf_data=0x1234; at N+2, mc_pend=0.
- Contention: continuous wb_elig writes to r3 while two MCU entries (r5, r6) are pushed.
  - mc_pend=2 and mc_ready=0.
  - After STARVE_MAX=4 denied cycles, wb_stall_req=1.
  - Bench drives wb_freeze=1: r5 written, then r6 written in order, counter returns to 0.
- flushpipe=1 with wb_we=1 (addr 9) and FIFO holding r4: rf_we writes r4, not r9.
- r0 handling:
  - WB write to r0 gives rf_we=0.
  - MCU entry for r0 pops with rf_we=0 and mc_pend decrements.
  - hz_addra=0 never raises hz_stall.
- Hazard and reset: FIFO holds r12; hz_addrb=12 gives hz_stall=1 and clears the cycle after r12 drains. Asserting rst with mc_pend=2 empties the FIFO and no writes occur.
